// File: rtl/inst_fetch_queue_pkg.sv
// ============================================================================
// Module  : inst_fetch_queue_pkg
// Purpose : Shared instruction-side constants for the fetch queue.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package inst_fetch_queue_pkg;

   localparam int          FETCHQ_DEPTH_DEFAULT = 4;
   localparam logic [31:0] INST_NOP             = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/inst_fetch_queue_ram.sv
// ============================================================================
// Module  : inst_fetch_queue_ram
// Purpose : Entry storage, one synchronous write port and one asynchronous read port.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_fetch_queue_ram
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH = FETCHQ_DEPTH_DEFAULT,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_waddr,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic [$clog2(DEPTH)-1:0] i_raddr,
   output logic [WIDTH-1:0]         o_rdata
);

   // The array has no reset; occupancy tracking in the parent masks stale data.
   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/inst_fetch_queue.sv
// ============================================================================
// Module  : inst_fetch_queue
// Purpose : Circular fetch-to-decode queue with flush; optional empty-queue
//           bypass enabled by defining FETCH_QUEUE_BYPASS_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int DEPTH = FETCHQ_DEPTH_DEFAULT,
   parameter int XLEN  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   input  logic [XLEN-1:0]            in_pc,
   input  logic [XLEN-1:0]            in_inst,
   output logic                       in_ready,
   output logic                       out_valid,
   output logic [XLEN-1:0]            out_pc,
   output logic [XLEN-1:0]            out_inst,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_PW = c_AW + 1;
   localparam int c_CW = $clog2(DEPTH+1);

   logic [c_PW-1:0]   r_wr_ptr;
   logic [c_PW-1:0]   r_rd_ptr;
   logic              r_ready_en;
   logic [c_PW-1:0]   w_occ;
   logic              w_full;
   logic              w_empty;
   logic              w_head_valid;
   logic              w_bypass;
   logic              w_push;
   logic              w_pop;
   logic [2*XLEN-1:0] w_rdata;

   assign w_occ   = r_wr_ptr - r_rd_ptr;
   assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                    (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign count   = c_CW'(w_occ);

   // r_ready_en keeps in_ready low until the first edge after reset release.
   assign in_ready     = r_ready_en && !w_full && !flush;
   assign w_head_valid = !w_empty && !flush;

`ifdef FETCH_QUEUE_BYPASS_EN
   assign w_bypass = r_ready_en && w_empty && in_valid && !flush;
`else
   assign w_bypass = 1'b0;
`endif

   assign out_valid = w_head_valid || w_bypass;
   assign w_pop     = w_head_valid && out_ready;
   // A bypassed entry taken by ID in the same cycle is never stored.
   assign w_push    = in_valid && in_ready && !(w_bypass && out_ready);

   always_comb begin
      out_pc   = '0;
      out_inst = '0;
      if (w_head_valid) begin
         {out_pc, out_inst} = w_rdata;
      end
`ifdef FETCH_QUEUE_BYPASS_EN
      else if (w_bypass) begin
         out_pc   = in_pc;
         out_inst = in_inst;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_ready_en <= 1'b0;
      end else begin
         r_ready_en <= 1'b1;
         if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
         end
      end
   end

   inst_fetch_queue_ram #(
      .DEPTH (DEPTH),
      .WIDTH (2*XLEN)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr[c_AW-1:0]),
      .i_wdata ({in_pc, in_inst}),
      .i_raddr (r_rd_ptr[c_AW-1:0]),
      .o_rdata (w_rdata)
   );

endmodule

`default_nettype wire

// File: doc/inst_fetch_queue.md
INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries; power of two, >= 2.
REQ-002 SHALL have parameter XLEN, default 32, width of pc and inst.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush  input  1  discard all entries (branch redirect).
REQ-006 SHALL have port in_valid  input  1  fetch side presents pc/inst.
REQ-007 SHALL have port in_pc  input  XLEN  fetched pc.
REQ-008 SHALL have port in_inst  input  XLEN  fetched instruction word.
REQ-009 SHALL have port in_ready  output  1  queue accepts an entry this cycle.
REQ-010 SHALL have port out_valid  output  1  head entry valid toward ID.
REQ-011 SHALL have port out_pc  output  XLEN  head pc.
REQ-012 SHALL have port out_inst  output  XLEN  head instruction.
REQ-013 SHALL have port out_ready  input  1  ID consumes head (driven low by hazard stall).
REQ-014 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-015 SHALL push on a clk edge when in_valid && in_ready, pop when out_valid && out_ready.
REQ-016 SHALL store entries in a circular buffer; read/write pointers $clog2(DEPTH)+1 bits, wrap DEPTH-1 -> 0, full = MSBs differ and low bits equal.
REQ-017 SHALL drive in_ready = (count < DEPTH) && !flush; when full, no push even if popping the same cycle.
REQ-018 SHALL drive out_valid = (count != 0) && !flush (bypass per REQ-026).
REQ-019 SHALL drive out_pc and out_inst as head entry when out_valid, else all zeros.
REQ-020 SHALL keep count unchanged on simultaneous push and pop; +1 on push only; -1 on pop only.
REQ-021 SHALL preserve FIFO order: entries leave in exactly push order.
REQ-022 SHALL, with flush high at an edge, set count and both pointers to 0 and ignore any push or pop in that cycle; flush has priority over all other events.
REQ-023 SHALL hold head stable (out_pc/out_inst unchanged) while out_valid && !out_ready.
REQ-024 SHALL never overflow or underflow: push with full or pop with empty is impossible via REQ-017/018.

Reset
REQ-025 SHALL, while rst low, asynchronously force count=0, pointers=0, out_valid=0, out_pc=0, out_inst=0, in_ready=0; in_ready rises only after first clk edge with rst high.

Configuration
REQ-026 SHALL, with FETCH_QUEUE_BYPASS_EN defined, when count==0 and in_valid && !flush, drive out_valid=1, out_pc=in_pc, out_inst=in_inst combinationally; if out_ready also high the entry is consumed and not stored (count stays 0), else it is stored normally.
REQ-027 SHALL, without FETCH_QUEUE_BYPASS_EN, have fixed minimum latency of one cycle from push to out_valid, no combinational path from in_* to out_*.

Structure
REQ-028 SHALL take default depth constant FETCHQ_DEPTH_DEFAULT and the NOP encoding from the shared instruction spec include, not local literals.
REQ-029 SHALL implement storage as one sub-module inst_fetch_queue_ram (DEPTH x 2*XLEN, one sync write port, one async read port, no reset on array).
REQ-030 SHALL keep pointer/count/flush control in inst_fetch_queue itself.

Verification
REQ-031 SHALL cover: reset, push pc=0x0,0x4,0x8,0xC (DEPTH=4), out_ready=0 -> count=4, in_ready=0, out_pc=0x0 held.
REQ-032 SHALL cover: full queue, out_ready=1 four cycles, in_valid=0 -> out_pc 0x0,0x4,0x8,0xC in order, then out_valid=0, count=0.
REQ-033 SHALL cover: count=2, in_valid=1 and out_ready=1 for 10 cycles -> count stays 2, pointers wrap, order preserved.
REQ-034 SHALL cover: count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, pushed entry absent.
REQ-035 SHALL cover: empty, in_valid=1 pc=0x100 out_ready=1 -> with BYPASS_EN out_valid=1 same cycle, count stays 0; without, out_valid=1 next cycle, count=1.
REQ-036 SHALL cover: rst driven low mid-stream with count=3 -> outputs zero immediately, no clk edge needed.
